// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column strobe, 2-flop row sync, full-scan debounce, single-key hex decode.
// Optional auto-repeat of the held key when KEYPAD_REPEAT_EN is defined.
module keypad_scanner #(
  parameter int SCAN_DIV       = 100000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int REPEAT_SCANS   = 200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key,
  output logic       key_valid,
  output logic       key_held
);
  localparam int DW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int SW = $clog2(DEBOUNCE_SCANS + 1);

  // Indexed by 4*c+r
  localparam logic [15:0][3:0] KEY_MAP = {
    4'hD, 4'hC, 4'hB, 4'hA,
    4'hE, 4'h9, 4'h6, 4'h3,
    4'hF, 4'h8, 4'h5, 4'h2,
    4'h0, 4'h7, 4'h4, 4'h1
  };

  logic [DW-1:0] div;
  logic [1:0]    cidx;
  logic [3:0]    row_meta, row_sync;
  logic [15:0]   snap, prev, deb;
  logic [15:0]   snap_full, deb_next;
  logic [SW-1:0] stable, stable_next;
  logic          sample, scan_end;
  logic          single;
  logic [3:0]    code;
  logic          rpt_fire;

  assign col      = ~(4'b0001 << cidx);
  assign sample   = (div == DW'(SCAN_DIV - 1));
  assign scan_end = sample && (cidx == 2'd3);

  always_comb begin
    snap_full = snap;
    for (int r = 0; r < 4; r++) snap_full[{cidx, 2'(r)}] = ~row_sync[r];
  end

  always_comb begin
    stable_next = SW'(1);
    if (snap_full == prev)
      stable_next = (stable == SW'(DEBOUNCE_SCANS)) ? stable : stable + SW'(1);
    deb_next = deb;
    if (scan_end && stable_next == SW'(DEBOUNCE_SCANS)) deb_next = snap_full;
  end

  always_comb begin
    single = ($countones(deb) == 1);
    code   = 4'h0;
    for (int i = 0; i < 16; i++) if (deb[i]) code = KEY_MAP[i];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row_meta <= 4'hF;
      row_sync <= 4'hF;
      div      <= '0;
      cidx     <= 2'd0;
      snap     <= '0;
      prev     <= '0;
      stable   <= '0;
      deb      <= '0;
    end else begin
      row_meta <= row;
      row_sync <= row_meta;
      div      <= sample ? '0 : div + DW'(1);
      if (sample) begin
        cidx <= cidx + 2'd1;
        snap <= snap_full;
      end
      if (scan_end) begin
        prev   <= snap_full;
        stable <= stable_next;
        deb    <= deb_next;
      end
    end
  end

`ifdef KEYPAD_REPEAT_EN
  localparam int RW = $clog2(REPEAT_SCANS + 1);
  logic [RW-1:0] rpt_cnt;

  // Counts whole scans over which the debounced single key is left untouched.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rpt_cnt  <= '0;
      rpt_fire <= 1'b0;
    end else begin
      rpt_fire <= 1'b0;
      if (scan_end) begin
        if (single && deb_next == deb) begin
          if (rpt_cnt == RW'(REPEAT_SCANS - 1)) begin
            rpt_cnt  <= '0;
            rpt_fire <= 1'b1;
          end else begin
            rpt_cnt <= rpt_cnt + RW'(1);
          end
        end else begin
          rpt_cnt <= '0;
        end
      end
    end
  end
`else
  assign rpt_fire = 1'b0;
`endif

  // key_held doubles as the previous single flag and key as the previous code.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      key       <= 4'h0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      key_held  <= single;
      key_valid <= (single && (!key_held || code != key)) || rpt_fire;
      if (single) key <= code;
    end
  end
endmodule

// File: tb/tb_keypad_scanner.sv
// Randomized/directed bench for keypad_scanner against a scan-level reference model.
module tb_keypad_scanner;
  localparam int SD = 4, DS = 2, RS = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] row, col, key;
  logic       key_valid, key_held;
  logic [15:0] pressed = '0;

  int total = 0, bad = 0;
  int vcnt = 0, last_total = 0;

  logic [3:0] km [4][4] = '{'{4'h1, 4'h2, 4'h3, 4'hA},
                            '{4'h4, 4'h5, 4'h6, 4'hB},
                            '{4'h7, 4'h8, 4'h9, 4'hC},
                            '{4'h0, 4'hF, 4'hE, 4'hD}};

  logic [15:0] m_prev, m_deb;
  int          m_cnt, m_rc;
  logic [3:0]  m_key;
  logic        m_held;

  logic [3:0]  obs_key, exp_key;
  logic        obs_held, exp_held;
  int          obs_str, exp_str;

  keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DS), .REPEAT_SCANS(RS)) dut (
    .clk(clk), .reset(reset), .row(row), .col(col),
    .key(key), .key_valid(key_valid), .key_held(key_held)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] kb(input int r, input int c);
    return 16'h1 << (4 * c + r);
  endfunction

  // Keypad wiring: a row reads low when a pressed key joins it to the driven column.
  function automatic logic [3:0] row_for(input logic [3:0] cl, input logic [15:0] p);
    logic [3:0] rr = 4'hF;
    for (int c = 0; c < 4; c++) begin
      logic [3:0] m = 4'b1 << c;
      if (cl == ~m) for (int r = 0; r < 4; r++) if (p[4*c+r]) rr[r] = 1'b0;
    end
    return rr;
  endfunction

  assign row = row_for(col, pressed);

  always @(posedge clk) if (key_valid === 1'b1) vcnt++;

  task automatic model_reset();
    m_prev = '0; m_deb = '0; m_cnt = 0; m_rc = 0; m_key = 4'h0; m_held = 1'b0;
    last_total = vcnt + int'(key_valid);
  endtask

  task automatic decode(input logic [15:0] s, output logic sg, output logic [3:0] cd);
    int n = 0;
    cd = 4'h0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (s[4*c+r]) begin n++; cd = km[r][c]; end
    sg = (n == 1);
  endtask

  task automatic model_step(input logic [15:0] p);
    logic [15:0] nd;
    logic sg, sg_old;
    logic [3:0] cd, cd_old;
    m_cnt  = (p == m_prev) ? ((m_cnt < DS) ? m_cnt + 1 : DS) : 1;
    m_prev = p;
    nd = (m_cnt == DS) ? p : m_deb;
    exp_str = 0;
    decode(m_deb, sg_old, cd_old);
`ifdef KEYPAD_REPEAT_EN
    if (nd == m_deb && sg_old) begin
      m_rc++;
      if (m_rc == RS) begin exp_str = 1; m_rc = 0; end
    end else m_rc = 0;
`endif
    m_deb = nd;
    decode(m_deb, sg, cd);
    if (sg && (!m_held || cd != m_key)) exp_str = 1;
    m_held = sg;
    if (sg) m_key = cd;
    exp_key = m_key; exp_held = m_held;
  endtask

  // Drive one full scan with key set p, then capture outputs one cycle into the next scan.
  task automatic do_scan(input logic [15:0] p);
    int n = 0;
    int t;
    pressed = p;
    model_step(p);
    while (col == 4'b1110 && n < 40) begin @(negedge clk); n++; end
    while (col != 4'b1110 && n < 40) begin @(negedge clk); n++; end
    if (n >= 40) begin
      bad++;
      $display("FAIL scan_timeout: col=%b never returned to 4'b1110", col);
    end
    total++;
    @(negedge clk);
    t = vcnt + int'(key_valid);
    obs_str = t - last_total;
    last_total = t;
    obs_key = key; obs_held = key_held;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (col !== 4'b1110) begin bad++; $display("FAIL reset_col: got %b want 1110", col); end
    total++; if (key !== 4'h0) begin bad++; $display("FAIL reset_key: got %h want 0", key); end
    total++; if (key_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", key_valid); end
    total++; if (key_held !== 1'b0) begin bad++; $display("FAIL reset_held: got %b want 0", key_held); end
    reset = 1'b1;
    model_reset();
    do_scan('0);
    total++; if ({obs_key, obs_held, obs_str} !== {exp_key, exp_held, exp_str}) begin
      bad++; $display("FAIL idle_scan: got k=%h h=%b s=%0d want k=%h h=%b s=%0d", obs_key, obs_held, obs_str, exp_key, exp_held, exp_str);
    end
  endtask

  task automatic test_single_press();
    int sum = 0;
    for (int i = 0; i < 3; i++) begin
      do_scan(kb(1, 2));
      sum += obs_str;
      total++; if ({obs_key, obs_held, obs_str} !== {exp_key, exp_held, exp_str}) begin
        bad++; $display("FAIL press6_scan%0d: got k=%h h=%b s=%0d want k=%h h=%b s=%0d", i, obs_key, obs_held, obs_str, exp_key, exp_held, exp_str);
      end
    end
    total++; if (obs_key !== 4'h6 || obs_held !== 1'b1) begin bad++; $display("FAIL press6_key: got k=%h h=%b want k=6 h=1", obs_key, obs_held); end
    total++; if (sum != 1) begin bad++; $display("FAIL press6_strobes: got %0d want 1", sum); end
  endtask

  task automatic test_hold_release();
    int sum = 0;
    for (int i = 0; i < 20; i++) begin
      do_scan(kb(1, 2));
      sum += obs_str;
      total++; if ({obs_key, obs_held, obs_str} !== {exp_key, exp_held, exp_str}) begin
        bad++; $display("FAIL hold6_scan%0d: got k=%h h=%b s=%0d want k=%h h=%b s=%0d", i, obs_key, obs_held, obs_str, exp_key, exp_held, exp_str);
      end
    end
`ifndef KEYPAD_REPEAT_EN
    total++; if (sum != 0) begin bad++; $display("FAIL hold6_no_repeat: got %0d strobes want 0", sum); end
`endif
    sum = 0;
    for (int i = 0; i < 4; i++) begin do_scan('0); sum += obs_str; end
    total++; if (obs_key !== 4'h6 || obs_held !== 1'b0 || sum != 0) begin
      bad++; $display("FAIL release6: got k=%h h=%b s=%0d want k=6 h=0 s=0", obs_key, obs_held, sum);
    end
  endtask

  task automatic test_bounce();
    int sum = 0;
    do_scan(kb(3, 3)); sum += obs_str;
    for (int i = 0; i < 4; i++) begin
      do_scan('0); sum += obs_str;
      total++; if (obs_held !== 1'b0) begin bad++; $display("FAIL bounceD_held: got %b want 0", obs_held); end
    end
    total++; if (sum != 0 || obs_key !== 4'h6) begin bad++; $display("FAIL bounceD: got s=%0d k=%h want s=0 k=6", sum, obs_key); end
  endtask

  task automatic test_multi_key();
    int sum = 0;
    for (int i = 0; i < 4; i++) begin do_scan(kb(0, 0) | kb(0, 1)); sum += obs_str; end
    total++; if (sum != 0 || obs_held !== 1'b0) begin bad++; $display("FAIL multi12: got s=%0d h=%b want s=0 h=0", sum, obs_held); end
    sum = 0;
    for (int i = 0; i < 3; i++) begin
      do_scan(kb(0, 0)); sum += obs_str;
      total++; if ({obs_key, obs_held, obs_str} !== {exp_key, exp_held, exp_str}) begin
        bad++; $display("FAIL multi_to_1_scan%0d: got k=%h h=%b s=%0d want k=%h h=%b s=%0d", i, obs_key, obs_held, obs_str, exp_key, exp_held, exp_str);
      end
    end
    total++; if (sum != 1 || obs_key !== 4'h1 || obs_held !== 1'b1) begin
      bad++; $display("FAIL multi_to_1: got s=%0d k=%h h=%b want s=1 k=1 h=1", sum, obs_key, obs_held);
    end
    for (int i = 0; i < 3; i++) do_scan('0);
  endtask

  task automatic test_reset_mid_scan();
    int n = 0, sum = 0;
    for (int i = 0; i < 3; i++) do_scan(kb(0, 3));
    total++; if (obs_key !== 4'hA || obs_held !== 1'b1) begin bad++; $display("FAIL preA: got k=%h h=%b want k=a h=1", obs_key, obs_held); end
    while (col != 4'b1011 && n < 80) begin @(negedge clk); n++; end
    @(negedge clk);
    reset = 1'b0;
    #1;
    total++; if (col !== 4'b1110 || key !== 4'h0 || key_held !== 1'b0) begin
      bad++; $display("FAIL midreset: got col=%b k=%h h=%b want col=1110 k=0 h=0", col, key, key_held);
    end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      do_scan(kb(0, 3)); sum += obs_str;
      total++; if ({obs_key, obs_held, obs_str} !== {exp_key, exp_held, exp_str}) begin
        bad++; $display("FAIL postreset_scan%0d: got k=%h h=%b s=%0d want k=%h h=%b s=%0d", i, obs_key, obs_held, obs_str, exp_key, exp_held, exp_str);
      end
    end
    total++; if (sum != 1 || obs_key !== 4'hA) begin bad++; $display("FAIL postresetA: got s=%0d k=%h want s=1 k=a", sum, obs_key); end
    for (int i = 0; i < 3; i++) do_scan('0);
  endtask

  task automatic test_random();
    logic [15:0] p;
    int dwell;
    for (int k = 0; k < 25; k++) begin
      case ($urandom_range(2, 0))
        0:       p = '0;
        1:       p = 16'h1 << $urandom_range(15, 0);
        default: p = (16'h1 << $urandom_range(15, 0)) | (16'h1 << $urandom_range(15, 0));
      endcase
      dwell = $urandom_range(4, 1);
      for (int d = 0; d < dwell; d++) begin
        do_scan(p);
        total++; if ({obs_key, obs_held, obs_str} !== {exp_key, exp_held, exp_str}) begin
          bad++; $display("FAIL random_%0d_%0d p=%h: got k=%h h=%b s=%0d want k=%h h=%b s=%0d", k, d, p, obs_key, obs_held, obs_str, exp_key, exp_held, exp_str);
        end
      end
    end
    for (int i = 0; i < 3; i++) do_scan('0);
  endtask

`ifdef KEYPAD_REPEAT_EN
  task automatic test_repeat();
    int sum = 0;
    for (int i = 0; i < 12; i++) begin
      do_scan(kb(2, 2)); sum += obs_str;
      total++; if ({obs_key, obs_held, obs_str} !== {exp_key, exp_held, exp_str}) begin
        bad++; $display("FAIL repeat9_scan%0d: got k=%h h=%b s=%0d want k=%h h=%b s=%0d", i, obs_key, obs_held, obs_str, exp_key, exp_held, exp_str);
      end
    end
    total++; if (sum < 4 || obs_key !== 4'h9) begin bad++; $display("FAIL repeat9: got s=%0d k=%h want s>=4 k=9", sum, obs_key); end
    for (int i = 0; i < 3; i++) do_scan('0);
  endtask
`endif

  initial begin
    test_reset();
    test_single_press();
    test_hold_release();
    test_bounce();
    test_multi_key();
    test_reset_mid_scan();
`ifdef KEYPAD_REPEAT_EN
    test_repeat();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
